// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and multiply/divide scheduler types.
// Division support is selected by MD_DIV_EN.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {
    IDLE,
    RUN
  } md_state_t;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MFHI,
    MD_MFLO,
    MD_MTHI,
    MD_MTLO
  } md_op_t;

  function automatic logic [31:0] neg32(
    input logic [31:0] v
  );
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational md-class decoder, instanced for D and E.
// div/divu decode only when MD_DIV_EN is defined.
module md_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_md,
  output logic        is_start_op,
  output md_op_t      op
);

  logic       sp;
  logic [5:0] fn;
  logic       unused_mid;

  assign sp = (instr[31:26] == OP_SPECIAL);
  assign fn = instr[5:0];
  assign unused_mid = ^instr[25:6];

  always_comb begin
    op = MD_NONE;
    unique case (1'b1)
      sp && (fn == F_MULT):  op = MD_MULT;
      sp && (fn == F_MULTU): op = MD_MULTU;
`ifdef MD_DIV_EN
      sp && (fn == F_DIV):   op = MD_DIV;
      sp && (fn == F_DIVU):  op = MD_DIVU;
`endif
      sp && (fn == F_MFHI):  op = MD_MFHI;
      sp && (fn == F_MFLO):  op = MD_MFLO;
      sp && (fn == F_MTHI):  op = MD_MTHI;
      sp && (fn == F_MTLO):  op = MD_MTLO;
      default:               op = MD_NONE;
    endcase
  end

  assign is_md = (op != MD_NONE);
  assign is_start_op = (op == MD_MULT)
                    || (op == MD_MULTU)
                    || (op == MD_DIV)
                    || (op == MD_DIVU);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: HI/LO owner, multi-cycle sequencing, stall merge.
// Define MD_DIV_EN to build in div/divu support.
module md_sched
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic [31:0] rs_valE,
  input  logic [31:0] rt_valE,
  input  logic        hazard_stall,
  output logic        stall,
  output logic        en_pc,
  output logic        en_D,
  output logic        clr_E,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES);
`ifdef MD_DIV_EN
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);
`endif

  logic   md_d;
  logic   start_d_unused;
  md_op_t op_d_unused;
  logic   md_e_unused;
  logic   start_op_e;
  md_op_t op_e;

  md_decode u_dec_d (
    .instr       (instrD),
    .is_md       (md_d),
    .is_start_op (start_d_unused),
    .op          (op_d_unused)
  );

  md_decode u_dec_e (
    .instr       (instrE),
    .is_md       (md_e_unused),
    .is_start_op (start_op_e),
    .op          (op_e)
  );

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_ld;
  md_op_t        op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi_q, lo_q;
  logic          start;
  logic          done;

  assign start = start_op_e && (state_q == IDLE);

`ifdef MD_DIV_EN
  assign cnt_ld = ((op_e == MD_DIV) || (op_e == MD_DIVU))
                ? DIV_LD : MUL_LD;
`else
  assign cnt_ld = MUL_LD;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = cnt_ld;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One 64x64 multiplier serves both signednesses via operand extension.
  logic        mul_sgn;
  logic [63:0] ext_a, ext_b, prod;

  assign mul_sgn = (op_q == MD_MULT);
  assign ext_a = {{32{mul_sgn & a_q[31]}}, a_q};
  assign ext_b = {{32{mul_sgn & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  logic        res_wr;
  logic [31:0] res_hi, res_lo;

`ifdef MD_DIV_EN
  logic        is_div, div_sgn;
  logic [31:0] mag_a, mag_b, uq, ur, sq, sr;

  assign is_div  = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign div_sgn = (op_q == MD_DIV);
  assign mag_a = (div_sgn && a_q[31]) ? neg32(a_q) : a_q;
  assign mag_b = (div_sgn && b_q[31]) ? neg32(b_q) : b_q;
  assign uq = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign ur = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
  // Quotient truncates toward zero; remainder follows the dividend.
  assign sq = (div_sgn && (a_q[31] ^ b_q[31])) ? neg32(uq) : uq;
  assign sr = (div_sgn && a_q[31]) ? neg32(ur) : ur;

  assign res_wr = done && (!is_div || (b_q != 32'd0));
  assign res_hi = is_div ? sr : prod[63:32];
  assign res_lo = is_div ? sq : prod[31:0];
`else
  assign res_wr = done;
  assign res_hi = prod[63:32];
  assign res_lo = prod[31:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (start) begin
        op_q <= op_e;
        a_q  <= rs_valE;
        b_q  <= rt_valE;
      end
      if (res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == IDLE) begin
        if (op_e == MD_MTHI) hi_q <= rs_valE;
        if (op_e == MD_MTLO) lo_q <= rs_valE;
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = hazard_stall | (md_d & (busy | start));
  assign en_pc = ~stall;
  assign en_D  = ~stall;
  assign clr_E = stall;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
